onehot_rr_arbiter8: RTL



---
 rtl/onehot_rr_arbiter8.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/onehot_rr_arbiter8.sv
// onehot_rr_arbiter8 -- upstream stage of encoder83.
// Captures rising edges on 8 request lines into a sticky pending set. It then
// hands pending requests out one at a time, in round-robin order, as a
// registered one-hot grant with a valid/ready handshake.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   req[7:0]     request lines; each 0->1 transition posts one request
//   grant[7:0]   registered one-hot grant, 0 when out_valid=0
//   out_valid    grant holds a valid request
//   out_ready    consumer accepts grant on out_valid && out_ready
//   pending_cnt  popcount of the pending set (registered)
//   overflow     1-cycle pulse: edge on an already-pending channel (merged)

// Per-channel edge detector and sticky pending bit.
module onehot_rr_lane (
  input  logic clk,
  input  logic rst,
  input  logic req_bit,
  input  logic load_bit,
  output logic req_edge,
  output logic pend_q,
  output logic pend_nxt
);
  logic req_q;

  assign req_edge = req_bit & ~req_q;
  // A set from a new edge wins over a clear from loading this channel.
  assign pend_nxt = (pend_q & ~load_bit) | req_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      req_q  <= req_bit;
      pend_q <= pend_nxt;
    end
  end
endmodule

module onehot_rr_arbiter8 #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             overflow
);
  localparam int PTR_W = $clog2(N);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_nxt;
  logic [N-1:0]     req_edge, pend_q, pend_nxt, load_mask;
  logic [PTR_W-1:0] ptr_q, sel_idx;
  logic             sel_found, load;
  logic [CNT_W-1:0] cnt_nxt;

  // ---------------------------------------------------------------- lanes
  for (genvar i = 0; i < N; i++) begin : g_lane
    onehot_rr_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .req_bit  (req[i]),
      .load_bit (load_mask[i]),
      .req_edge (req_edge[i]),
      .pend_q   (pend_q[i]),
      .pend_nxt (pend_nxt[i])
    );
  end

  // ------------------------------------------------------------ selection
  // First pending bit at or after ptr, wrapping; the PTR_W-bit add wraps 7->0.
  // Only the registered pending set is searched, never the same-cycle edge.
  always_comb begin
    logic [PTR_W-1:0] idx;
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + PTR_W'(k);
      if (!sel_found && pend_q[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  // Load when the output slot is empty or is being drained this edge.
  assign load      = sel_found && (state_q == EMPTY || out_ready);
  assign load_mask = load ? (N'(1) << sel_idx) : '0;

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < N; k++) cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[k]);
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      EMPTY:   if (sel_found) state_nxt = FULL;
      FULL:    if (out_ready) state_nxt = sel_found ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
  end

  // ---------------------------------------------------- registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      ptr_q       <= '0;
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      if (load) begin
        grant <= load_mask;
        ptr_q <= sel_idx + PTR_W'(1);
      end else if (state_q == FULL && out_ready) begin
        grant <= '0;
      end
      pending_cnt <= cnt_nxt;
      // An edge on the channel being loaded re-posts it; that is not a loss.
      overflow    <= |(req_edge & pend_q & ~load_mask);
    end
  end
endmodule
